// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit for the Datapath. Fetches an instruction
//   (T0-T2) and executes a three-register ALU operation (T3-T5).
//   All outputs are decoded from the state register and the latched
//   IR fields. They never depend directly on run or mem_ready.
//
// Ports
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-high reset
//   run        in   level; start or continue fetching (sampled in IDLE and T5)
//   mem_ready  in   memory read data valid
//   ir[31:0]   in   current Datapath IR value
//   enable     out  register load enables (bit map shared with busSelect)
//   busSelect  out  one-hot bus source select
//   MR_Read    out  memory read strobe to the MDR mux
//   inc_pc     out  PC increment request
//   alu_op     out  ALU opcode (valid in T4 only)
//   busy       out  high outside IDLE, HALT and FAULT
//   fault      out  sticky error flag (memory timeout or illegal opcode)
//
// Optional feature
//   INSTR_COUNT_EN: adds output instr_count[31:0], which counts completed
//   instructions (T5 exits) and wraps at 2^32.
module control_sequencer #(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [4:0] ALU_OP_MAX  = 5'b01011,
    parameter logic [4:0] HALT_OP     = 5'b11011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        MR_Read,
    output logic        inc_pc,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        fault
`ifdef INSTR_COUNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    localparam int BIT_ZLOW = 19;
    localparam int BIT_PC   = 20;
    localparam int BIT_MDR  = 21;
    localparam int BIT_IR   = 23;
    localparam int BIT_Z    = 24;
    localparam int BIT_MAR  = 25;
    localparam int BIT_Y    = 27;

    // The counter only has to reach MEM_TIMEOUT-1. The timeout fires on the
    // cycle that would take it to MEM_TIMEOUT.
    localparam int               WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [3:0]        ra_q, ra_d;
    logic [3:0]        rb_q, rb_d;
    logic [3:0]        rc_q, rc_d;
    logic              fault_q, fault_d;
`ifdef INSTR_COUNT_EN
    logic [31:0]       count_q, count_d;
`endif

    // The low IR bits carry immediates. This unit does not decode them.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[14:0];

    // Next-state logic. The wait counter defaults to clearing, so it only
    // holds a value while the FSM sits in T1 waiting for memory. The IR
    // fields are captured on the edge that leaves T2, so T3 and later states
    // decode a stable copy even if the Datapath IR changes afterwards.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        opcode_d   = opcode_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        fault_d    = fault_q;
`ifdef INSTR_COUNT_EN
        count_d    = count_q;
`endif
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_T2: begin
                state_d  = S_T3;
                opcode_d = ir[31:27];
                ra_d     = ir[26:23];
                rb_d     = ir[22:19];
                rc_d     = ir[18:15];
            end
            S_T3: begin
                if (opcode_q <= ALU_OP_MAX) begin
                    state_d = S_T4;
                end else if (opcode_q == HALT_OP) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                state_d = run ? S_T0 : S_IDLE;
`ifdef INSTR_COUNT_EN
                count_d = count_q + 32'd1;
`endif
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Every flop in the block. clr returns to IDLE immediately and clears
    // the sticky fault flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            opcode_q   <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rc_q       <= '0;
            fault_q    <= 1'b0;
`ifdef INSTR_COUNT_EN
            count_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opcode_q   <= opcode_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rc_q       <= rc_d;
            fault_q    <= fault_d;
`ifdef INSTR_COUNT_EN
            count_q    <= count_d;
`endif
        end
    end

    // Moore output decode from registered state and IR fields only.
    always_comb begin
        enable    = '0;
        busSelect = '0;
        MR_Read   = 1'b0;
        inc_pc    = 1'b0;
        alu_op    = '0;
        busy      = 1'b0;
        case (state_q)
            S_T0: begin
                busSelect[BIT_PC] = 1'b1;
                enable[BIT_MAR]   = 1'b1;
                enable[BIT_PC]    = 1'b1;
                inc_pc            = 1'b1;
                busy              = 1'b1;
            end
            S_T1: begin
                MR_Read         = 1'b1;
                enable[BIT_MDR] = 1'b1;
                busy            = 1'b1;
            end
            S_T2: begin
                busSelect[BIT_MDR] = 1'b1;
                enable[BIT_IR]     = 1'b1;
                busy               = 1'b1;
            end
            S_T3: begin
                busSelect[{1'b0, rb_q}] = 1'b1;
                enable[BIT_Y]           = 1'b1;
                busy                    = 1'b1;
            end
            S_T4: begin
                busSelect[{1'b0, rc_q}] = 1'b1;
                enable[BIT_Z]           = 1'b1;
                alu_op                  = opcode_q;
                busy                    = 1'b1;
            end
            S_T5: begin
                busSelect[BIT_ZLOW]  = 1'b1;
                enable[{1'b0, ra_q}] = 1'b1;
                busy                 = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault = fault_q;
`ifdef INSTR_COUNT_EN
    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Self-checking bench for control_sequencer. Each instruction is expanded
//   into the per-cycle control trace it should produce: fetch, wait states,
//   then execute, halt or fault. The trace also carries the mem_ready and run
//   values to drive on each cycle. The DUT is compared against this trace
//   cycle by cycle on the falling clock edge.
module tb_control_sequencer;

    localparam int         MEM_TIMEOUT = 15;
    localparam logic [4:0] ALU_OP_MAX  = 5'b01011;
    localparam logic [4:0] HALT_OP     = 5'b11011;

    logic        clk;
    logic        clr;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic        MR_Read;
    logic        inc_pc;
    logic [4:0]  alu_op;
    logic        busy;
    logic        fault;
`ifdef INSTR_COUNT_EN
    logic [31:0] instr_count;
    int unsigned modelCount = 0;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    bit atT0        = 1'b0;

    typedef struct {
        logic [31:0] en;
        logic [31:0] bs;
        logic        mr;
        logic        inc;
        logic [4:0]  op;
        logic        busy;
        logic        flt;
        logic        memReady;
        logic        runIn;
    } cycle_t;

    cycle_t trace[$];

    control_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .run       (run),
        .mem_ready (mem_ready),
        .ir        (ir),
        .enable    (enable),
        .busSelect (busSelect),
        .MR_Read   (MR_Read),
        .inc_pc    (inc_pc),
        .alu_op    (alu_op),
        .busy      (busy),
        .fault     (fault)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cycle_t quiet();
        cycle_t c;
        c.en = '0; c.bs = '0; c.mr = 1'b0; c.inc = 1'b0; c.op = '0;
        c.busy = 1'b0; c.flt = 1'b0; c.memReady = 1'b0; c.runIn = 1'b0;
        return c;
    endfunction

    function automatic logic [31:0] makeInstr(input logic [4:0] opc, input logic [3:0] ra,
                                              input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'($urandom)};
    endfunction

    task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] wanted);
        testsRun++;
        assert (observed === wanted) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, wanted);
        end
    endtask

    task automatic checkOutput(input string tag, input cycle_t e);
        checkField({tag, ".enable"},    enable,           e.en);
        checkField({tag, ".busSelect"}, busSelect,        e.bs);
        checkField({tag, ".MR_Read"},   32'(MR_Read),     32'(e.mr));
        checkField({tag, ".inc_pc"},    32'(inc_pc),      32'(e.inc));
        checkField({tag, ".alu_op"},    32'(alu_op),      32'(e.op));
        checkField({tag, ".busy"},      32'(busy),        32'(e.busy));
        checkField({tag, ".fault"},     32'(fault),       32'(e.flt));
    endtask

    // Append n cycles of a terminal state: HALT is all zero, FAULT only raises fault.
    task automatic addStuck(input bit isFault, input int n);
        cycle_t c;
        for (int i = 0; i < n; i++) begin
            c = quiet();
            c.flt      = isFault;
            c.runIn    = 1'b1;
            c.memReady = 1'($urandom_range(0, 1));
            trace.push_back(c);
        end
    endtask

    // Reference model: the whole expected trace of one instruction starting at T0.
    task automatic buildTrace(input logic [31:0] instr, input int waits,
                              input logic lastRun, output bit completes);
        cycle_t     c;
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        int         nT1;
        bit         timeout;
        opc = instr[31:27];
        ra  = instr[26:23];
        rb  = instr[22:19];
        rc  = instr[18:15];
        completes = 1'b0;
        trace.delete();

        c = quiet();
        c.bs = 32'h1 << 20; c.en = (32'h1 << 25) | (32'h1 << 20); c.inc = 1'b1; c.busy = 1'b1;
        c.runIn = 1'($urandom_range(0, 1));
        trace.push_back(c);

        timeout = (waits >= MEM_TIMEOUT);
        nT1     = timeout ? MEM_TIMEOUT : waits + 1;
        for (int i = 0; i < nT1; i++) begin
            c = quiet();
            c.mr = 1'b1; c.en = 32'h1 << 21; c.busy = 1'b1;
            c.memReady = (!timeout && i == waits);
            c.runIn    = 1'($urandom_range(0, 1));
            trace.push_back(c);
        end
        if (timeout) begin
            addStuck(1'b1, 3);
            return;
        end

        c = quiet();
        c.bs = 32'h1 << 21; c.en = 32'h1 << 23; c.busy = 1'b1;
        c.runIn = 1'($urandom_range(0, 1));
        trace.push_back(c);

        c = quiet();
        c.bs = 32'h1 << rb; c.en = 32'h1 << 27; c.busy = 1'b1;
        c.runIn = 1'($urandom_range(0, 1));
        trace.push_back(c);

        if (opc <= ALU_OP_MAX) begin
            c = quiet();
            c.bs = 32'h1 << rc; c.en = 32'h1 << 24; c.op = opc; c.busy = 1'b1;
            c.runIn = 1'($urandom_range(0, 1));
            trace.push_back(c);
            c = quiet();
            c.bs = 32'h1 << 19; c.en = 32'h1 << ra; c.busy = 1'b1;
            c.runIn = lastRun;
            trace.push_back(c);
            completes = 1'b1;
        end else if (opc == HALT_OP) begin
            addStuck(1'b0, 4);
        end else begin
            addStuck(1'b1, 3);
        end
    endtask

    // Walk one instruction from T0, checking and driving every cycle.
    task automatic applyStimulus(input logic [31:0] instr, input int waits,
                                 input logic lastRun, input string tag);
        bit     completes;
        cycle_t c;
        int     step;
        buildTrace(instr, waits, lastRun, completes);
        ir   = instr;
        step = 0;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            checkOutput($sformatf("%s.c%0d", tag, step), c);
            mem_ready = c.memReady;
            run       = c.runIn;
            @(negedge clk);
            step++;
        end
        atT0 = completes && lastRun;
`ifdef INSTR_COUNT_EN
        if (completes) begin
            modelCount++;
            checkField({tag, ".instr_count"}, instr_count, 32'(modelCount));
        end
`endif
    endtask

    task automatic startFromIdle(input string tag);
        checkOutput({tag, ".idle"}, quiet());
        run = 1'b1;
        @(negedge clk);
        atT0 = 1'b1;
    endtask

    task automatic ensureT0(input string tag);
        if (!atT0) startFromIdle(tag);
    endtask

    task automatic doReset(input string tag);
        clr       = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput(tag, quiet());
`ifdef INSTR_COUNT_EN
        modelCount = 0;
        checkField({tag, ".instr_count"}, instr_count, 32'd0);
`endif
        clr = 1'b0;
        @(negedge clk);
        atT0 = 1'b0;
    endtask

    initial begin
        clr = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
        doReset("reset");

        // Asynchronous clear while waiting for memory in T1.
        ir  = 32'h489A8000;
        run = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkField("midT1.MR_Read", 32'(MR_Read), 32'd1);
        #2 clr = 1'b1;
        #1 checkOutput("clrAsync", quiet());
        doReset("clrHold");

        // shl R1,R3,R5 with no wait states, then back-to-back instructions.
        ensureT0("shl");
        applyStimulus(32'h489A8000, 0, 1'b1, "shl");
        applyStimulus(makeInstr(5'($urandom_range(0, 11)), 4'($urandom), 4'($urandom), 4'($urandom)),
                      3, 1'b1, "wait3");
        applyStimulus(makeInstr(5'd0, 4'd7, 4'd7, 4'd7), 14, 1'b0, "wait14SameRegs");
        ensureT0("rbEqRc");
        applyStimulus(makeInstr(5'd11, 4'd15, 4'd9, 4'd9), 1, 1'b1, "rbEqRc");

        for (int i = 0; i < 16; i++) begin
            ensureT0($sformatf("rand%0d", i));
            applyStimulus(makeInstr(5'($urandom_range(0, 11)), 4'($urandom), 4'($urandom), 4'($urandom)),
                          int'($urandom_range(0, 4)), 1'((i % 4) != 3), $sformatf("rand%0d", i));
        end

        ensureT0("halt");
        applyStimulus(makeInstr(HALT_OP, 4'($urandom), 4'($urandom), 4'($urandom)), 1, 1'b1, "halt");
        doReset("afterHalt");

        ensureT0("illegal");
        applyStimulus(makeInstr(5'b11111, 4'($urandom), 4'($urandom), 4'($urandom)), 0, 1'b1, "illegal");
        doReset("afterIllegal");

        ensureT0("timeout");
        applyStimulus(makeInstr(5'd3, 4'd2, 4'd4, 4'd6), 15, 1'b1, "timeout");
        doReset("afterTimeout");

        // Two completed instructions after a fresh reset.
        ensureT0("pair");
        applyStimulus(makeInstr(5'd1, 4'd3, 4'd3, 4'd8), 0, 1'b1, "pairA");
        applyStimulus(makeInstr(5'd5, 4'd12, 4'd0, 4'd14), 2, 1'b0, "pairB");
        checkOutput("finalIdle", quiet());

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the Datapath's register-enable, bus-select, memory-read and ALU-opcode controls.
- Sequences instruction fetch (T0–T2) and three-register ALU execution (T3–T5) from the Datapath's IR contents.
- Replaces hand-written per-state stimulus with a synthesizable Moore FSM.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles in T1 for mem_ready before entering FAULT.
- ALU_OP_MAX, 5'b01011, highest opcode treated as a three-register ALU op.
- HALT_OP, 5'b11011, opcode that stops the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- run  in  1  level; while high, the sequencer starts or continues fetching.
- mem_ready  in  1  memory has returned data (MDataIn valid) during a read.
- ir  in  32  current IR register value from the Datapath.
- enable  out  32  one-hot-per-bit register load enables.
- busSelect  out  32  one-hot bus source select (at most one bit set).
- MR_Read  out  1  memory read strobe to the MDR mux.
- inc_pc  out  1  PC increment request.
- alu_op  out  5  ALU opcode.
- busy  out  1  high in any state other than IDLE, HALT or FAULT.
- fault  out  1  sticky error flag.

Behaviour:
- Bit map, shared by enable and busSelect:
  - 0–15 = R0–R15
  - 16 = HI, 17 = LO, 18 = Zhigh, 19 = Zlow
  - 20 = PC, 21 = MDR, 22 = InPort, 23 = IR
  - 24 = Z, 25 = MAR, 26 = OutPort, 27 = Y
  - 28–31 unused, always 0
- IR fields: opcode = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT, FAULT.
  - State is registered.
  - Outputs are a combinational decode of the state register and the registered IR fields only (Moore style, no dependency on run or mem_ready).
- Reset (clr=1, asynchronous):
  - state = IDLE; wait counter = 0; fault = 0.
  - All outputs 0: enable, busSelect, MR_Read, inc_pc, alu_op, busy.
- IDLE: all outputs 0. run=1 -> T0.
- T0: busSelect[20]; enable[25] and enable[20]; inc_pc=1. -> T1.
- T1: MR_Read=1; enable[21].
  - mem_ready=1 -> T2.
  - Otherwise stay in T1 and increment the wait counter.
  - Counter reaching MEM_TIMEOUT with mem_ready still 0 -> FAULT.
  - Counter clears on leaving T1.
- T2: busSelect[21]; enable[23]. Latch ir fields into internal registers at the end of T2+1 (first T3 edge). -> T3.
- Transition out of T3, evaluated on the freshly loaded IR:
  - opcode <= ALU_OP_MAX -> continue (T3 outputs: busSelect[Rb], enable[27]).
  - opcode == HALT_OP -> HALT. HALT outputs are all 0 except busy=0.
  - Any other opcode -> FAULT.
- T4: busSelect[Rc]; enable[24]; alu_op = opcode. -> T5.
- T5: busSelect[19]; enable[Ra]. -> T0 if run=1, else IDLE.
- Instruction latency: 6 cycles plus T1 wait states.
- FAULT sets fault=1 and all other outputs 0. Only clr exits FAULT or HALT.
- Register-index corner cases:
  - Rb == Rc is legal: two separate cycles.
  - Ra == Rb is legal: writeback in T5 happens after the read in T3.
- run deasserted mid-instruction: the instruction completes; run is sampled only in IDLE and T5.
- clr mid-operation (e.g. during T1 wait): immediate return to IDLE with outputs 0, with no partial-cycle glitches beyond the asynchronous clear.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count [31:0], reset to 0 by clr.
  - Increments by 1 on each T5 -> T0/IDLE transition; wraps from 32'hFFFFFFFF to 0.
  - HALT and FAULT do not increment it.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset check: clr pulse mid-T1 -> next sample state IDLE, all outputs 32'h0 or 0, fault=0.
- shl decode: run=1, mem_ready=1, IR loaded with 32'h489A8000 (shl R1,R3,R5), checked per state:
  - T3 busSelect=32'h00000008, enable=32'h08000000
  - T4 busSelect=32'h00000020, enable=32'h01000000, alu_op=5'b01001
  - T5 busSelect=32'h00080000, enable=32'h00000002
- Fetch controls: T0 busSelect=32'h00100000, enable=32'h02100000, inc_pc=1; T2 busSelect=32'h00200000, enable=32'h00800000.
- Wait states: mem_ready held 0 for 3 cycles in T1 -> MR_Read=1 for 4 cycles, then T2. Holding it 0 for 15 cycles -> FAULT with fault=1.
- Halt and illegal opcodes: IR opcode 5'b11011 -> HALT with busy=0, no further enables even with run=1. Opcode 5'b11111 -> FAULT.
- Back-to-back instructions: run held 1 -> T5 followed directly by T0. With INSTR_COUNT_EN, two completed instructions give instr_count=2.
